extbus_sync: RTL and testbench

- Bus front end between the 6502-style external bus pins (cs_n/rd_n/wr_n, 5-bit address, 8-bit data) and the VERA register file, in the clk25 domain.
- Synchronises the asynchronous strobes into the clock domain.
- Converts each completed write into a single-cycle register write strobe with its captured address and data.
- Drives read data back onto the bus and reports each completed read, so the register file can apply side effects such as address auto-increment.

---
 rtl/extbus_sync.sv | 201 ++++++++++++++++++++
 tb/tb_extbus_sync.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extbus_sync.sv
// Bus front end between the asynchronous 6502-style external bus and the register file.
// Synchronises the strobes and turns each completed access into a single-cycle pulse.
module extbus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       extbus_cs_n,
  input  logic       extbus_rd_n,
  input  logic       extbus_wr_n,
  input  logic [4:0] extbus_a,
  input  logic [7:0] extbus_d_i,
  output logic [7:0] extbus_d_o,
  output logic       extbus_d_oe,
  output logic [4:0] reg_rd_addr,
  input  logic [7:0] reg_rd_data,
  output logic       reg_wr,
  output logic [4:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_done,
  output logic [4:0] reg_rd_done_addr,
  output logic       bus_err,
  input  logic       err_clr
);

  localparam logic [2:0] ST_ARM      = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_WR_ACT   = 3'd2;
  localparam logic [2:0] ST_RD_ACT   = 3'd3;
  localparam logic [2:0] ST_ERR_WAIT = 3'd4;

  localparam logic [1:0] ARM_CYCLES = SYNC_STAGES[1:0];

  logic       w_wr_act;
  logic       w_rd_act;
  logic       w_s_wr;
  logic       w_s_rd;
  logic [4:0] w_s_a;
  logic [7:0] w_s_d;

  logic       r_wr_sync [SYNC_STAGES];
  logic       r_rd_sync [SYNC_STAGES];
  logic [4:0] r_a_sync  [SYNC_STAGES];
  logic [7:0] r_d_sync  [SYNC_STAGES];

  logic [2:0] r_state;
  logic [1:0] r_arm_cnt;
  logic [4:0] r_hold_a;
  logic [7:0] r_hold_d;
  logic       r_oe_en;
  logic       r_reg_wr;
  logic [4:0] r_reg_wr_addr;
  logic [7:0] r_reg_wr_data;
  logic       r_reg_rd_done;
  logic [4:0] r_reg_rd_done_addr;
  logic       r_bus_err;

  logic [2:0] w_state_next;
  logic       w_arm_inc;
  logic       w_load_a;
  logic       w_load_d;
  logic       w_wr_pulse;
  logic       w_rd_pulse;
  logic       w_err_set;

  assign w_wr_act = ~extbus_cs_n & ~extbus_wr_n;
  assign w_rd_act = ~extbus_cs_n & ~extbus_rd_n;

  // Strobes, address and data travel through the chain in lockstep so the
  // last active strobe sample is always paired with its own address/data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_wr_sync[i] <= 1'b0;
        r_rd_sync[i] <= 1'b0;
        r_a_sync[i]  <= 5'd0;
        r_d_sync[i]  <= 8'd0;
      end
    end else begin
      r_wr_sync[0] <= w_wr_act;
      r_rd_sync[0] <= w_rd_act;
      r_a_sync[0]  <= extbus_a;
      r_d_sync[0]  <= extbus_d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_wr_sync[i] <= r_wr_sync[i-1];
        r_rd_sync[i] <= r_rd_sync[i-1];
        r_a_sync[i]  <= r_a_sync[i-1];
        r_d_sync[i]  <= r_d_sync[i-1];
      end
    end
  end

  assign w_s_wr = r_wr_sync[SYNC_STAGES-1];
  assign w_s_rd = r_rd_sync[SYNC_STAGES-1];
  assign w_s_a  = r_a_sync[SYNC_STAGES-1];
  assign w_s_d  = r_d_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_next = r_state;
    w_arm_inc    = 1'b0;
    w_load_a     = 1'b0;
    w_load_d     = 1'b0;
    w_wr_pulse   = 1'b0;
    w_rd_pulse   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      // The chain holds reset values until refilled, so wait for live samples
      // before judging whether a strobe was already active at reset release.
      ST_ARM: begin
        if (r_arm_cnt != ARM_CYCLES) begin
          w_arm_inc = 1'b1;
        end else if (!w_s_wr && !w_s_rd) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_s_wr && w_s_rd) begin
          w_err_set    = 1'b1;
          w_state_next = ST_ERR_WAIT;
        end else if (w_s_wr) begin
          w_load_a     = 1'b1;
          w_load_d     = 1'b1;
          w_state_next = ST_WR_ACT;
        end else if (w_s_rd) begin
          w_load_a     = 1'b1;
          w_state_next = ST_RD_ACT;
        end
      end
      ST_WR_ACT: begin
        if (w_s_rd) begin
          w_err_set    = 1'b1;
          w_state_next = ST_ERR_WAIT;
        end else if (w_s_wr) begin
          w_load_a = 1'b1;
          w_load_d = 1'b1;
        end else begin
          w_wr_pulse   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_RD_ACT: begin
        if (w_s_wr) begin
          w_err_set    = 1'b1;
          w_state_next = ST_ERR_WAIT;
        end else if (!w_s_rd) begin
          w_rd_pulse   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR_WAIT: begin
        if (!w_s_wr && !w_s_rd) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= ST_ARM;
      r_arm_cnt          <= 2'd0;
      r_hold_a           <= 5'd0;
      r_hold_d           <= 8'd0;
      r_oe_en            <= 1'b0;
      r_reg_wr           <= 1'b0;
      r_reg_wr_addr      <= 5'd0;
      r_reg_wr_data      <= 8'd0;
      r_reg_rd_done      <= 1'b0;
      r_reg_rd_done_addr <= 5'd0;
      r_bus_err          <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_oe_en       <= 1'b1;
      r_reg_wr      <= w_wr_pulse;
      r_reg_rd_done <= w_rd_pulse;
      if (w_arm_inc) r_arm_cnt <= r_arm_cnt + 2'd1;
      if (w_load_a)  r_hold_a  <= w_s_a;
      if (w_load_d)  r_hold_d  <= w_s_d;
      if (w_wr_pulse) begin
        r_reg_wr_addr <= r_hold_a;
        r_reg_wr_data <= r_hold_d;
      end
      if (w_rd_pulse) r_reg_rd_done_addr <= r_hold_a;
      // A fresh error beats a simultaneous clear request.
      if (w_err_set)    r_bus_err <= 1'b1;
      else if (err_clr) r_bus_err <= 1'b0;
    end
  end

  assign extbus_d_o       = reg_rd_data;
  assign extbus_d_oe      = r_oe_en & ~extbus_cs_n & ~extbus_rd_n & extbus_wr_n;
  assign reg_rd_addr      = extbus_a;
  assign reg_wr           = r_reg_wr;
  assign reg_wr_addr      = r_reg_wr_addr;
  assign reg_wr_data      = r_reg_wr_data;
  assign reg_rd_done      = r_reg_rd_done;
  assign reg_rd_done_addr = r_reg_rd_done_addr;
  assign bus_err          = r_bus_err;

endmodule

// File: tb/tb_extbus_sync.sv
// Directed bench for extbus_sync: 25 MHz clock, bus cycles driven with
// asynchronous timing relative to clk, pulses collected by a negedge monitor.
`timescale 1ns/1ps
module tb_extbus_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       extbus_cs_n, extbus_rd_n, extbus_wr_n;
  logic [4:0] extbus_a;
  logic [7:0] extbus_d_i;
  logic [7:0] extbus_d_o;
  logic       extbus_d_oe;
  logic [4:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  logic       reg_wr;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_rd_done;
  logic [4:0] reg_rd_done_addr;
  logic       bus_err;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;

  logic [12:0] wr_q[$];
  logic [4:0]  rd_q[$];

  always #20 clk = ~clk;

  extbus_sync #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .extbus_cs_n(extbus_cs_n), .extbus_rd_n(extbus_rd_n), .extbus_wr_n(extbus_wr_n),
    .extbus_a(extbus_a), .extbus_d_i(extbus_d_i),
    .extbus_d_o(extbus_d_o), .extbus_d_oe(extbus_d_oe),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_done(reg_rd_done), .reg_rd_done_addr(reg_rd_done_addr),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  // Each high cycle of a pulse is logged, so a stretched pulse shows as a duplicate.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_q.push_back({reg_wr_addr, reg_wr_data});
      $display("pulse reg_wr addr=%0h data=%02h", reg_wr_addr, reg_wr_data);
    end
    if (reg_rd_done) begin
      rd_q.push_back(reg_rd_done_addr);
      $display("pulse reg_rd_done addr=%0h", reg_rd_done_addr);
    end
  end

  // 8 MHz style write: strobe low ~62 ns, address/data set up before it.
  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #5;
    extbus_a = a; extbus_d_i = d;
    #10 extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
    #62 extbus_wr_n = 1'b1;
    #15 extbus_cs_n = 1'b1;
    #33;
  endtask

  task automatic test_reset();
    extbus_cs_n = 1'b0; extbus_rd_n = 1'b0; extbus_a = 5'h0A;
    repeat (3) @(posedge clk);
    #1;
    if (reg_wr !== 1'b0) begin failures++; $display("FAIL reset_reg_wr got=%b exp=0", reg_wr); end
    checks++;
    if (reg_rd_done !== 1'b0) begin failures++; $display("FAIL reset_rd_done got=%b exp=0", reg_rd_done); end
    checks++;
    if (reg_wr_addr !== 5'd0 || reg_wr_data !== 8'd0) begin
      failures++; $display("FAIL reset_wr_regs got=%h/%h exp=0/0", reg_wr_addr, reg_wr_data);
    end
    checks++;
    if (reg_rd_done_addr !== 5'd0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", reg_rd_done_addr); end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    checks++;
    if (extbus_d_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", extbus_d_oe); end
    checks++;
    if (reg_rd_addr !== 5'h0A) begin failures++; $display("FAIL reset_rd_addr_pass got=%h exp=0a", reg_rd_addr); end
    checks++;
    extbus_cs_n = 1'b1; extbus_rd_n = 1'b1;
    @(posedge clk); #5 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    $display("test_reset done");
  endtask

  task automatic test_write();
    int  n;
    bit  found;
    wr_q.delete(); rd_q.delete();
    @(posedge clk); #5;
    extbus_a = 5'h05; extbus_d_i = 8'h01;
    #10 extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
    #62 extbus_wr_n = 1'b1; extbus_cs_n = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); n++; #1;
      if (reg_wr) found = 1'b1;
    end
    if (!found || n < 3 || n > 4) begin
      failures++; $display("FAIL write_latency got=%0d found=%0b exp=3..4", n, found);
    end
    checks++;
    repeat (8) @(posedge clk);
    if (wr_q.size() != 1) begin failures++; $display("FAIL write_count got=%0d exp=1", wr_q.size()); end
    else if (wr_q[0] !== {5'h05, 8'h01}) begin
      failures++; $display("FAIL write_value got=%h exp=%h", wr_q[0], {5'h05, 8'h01});
    end
    checks++;
    if (rd_q.size() != 0) begin failures++; $display("FAIL write_no_rd got=%0d exp=0", rd_q.size()); end
    checks++;
    $display("test_write addr=05 data=01 latency=%0d", n);
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_v [7];
    exp_v[0] = {5'h00, 8'h00}; exp_v[1] = {5'h01, 8'h40}; exp_v[2] = {5'h02, 8'h10};
    exp_v[3] = {5'h04, 8'hA1}; exp_v[4] = {5'h04, 8'hA2}; exp_v[5] = {5'h04, 8'hA3};
    exp_v[6] = {5'h04, 8'hA4};
    wr_q.delete();
    for (int i = 0; i < 7; i++) bus_write(exp_v[i][12:8], exp_v[i][7:0]);
    repeat (8) @(posedge clk);
    if (wr_q.size() != 7) begin failures++; $display("FAIL b2b_count got=%0d exp=7", wr_q.size()); end
    checks++;
    for (int i = 0; i < 7; i++) begin
      if (i < wr_q.size()) begin
        if (wr_q[i] !== exp_v[i]) begin
          failures++; $display("FAIL b2b_entry%0d got=%h exp=%h", i, wr_q[i], exp_v[i]);
        end
        checks++;
      end
    end
    #1;
    if (reg_wr_addr !== 5'h04 || reg_wr_data !== 8'hA4) begin
      failures++; $display("FAIL b2b_hold got=%h/%h exp=04/a4", reg_wr_addr, reg_wr_data);
    end
    checks++;
    $display("test_back_to_back pulses=%0d", wr_q.size());
  endtask

  task automatic test_read();
    wr_q.delete(); rd_q.delete();
    reg_rd_data = 8'hA1;
    @(posedge clk); #5;
    extbus_a = 5'h04; extbus_cs_n = 1'b0;
    #5;
    if (extbus_d_oe !== 1'b0) begin failures++; $display("FAIL read_oe_cs_only got=%b exp=0", extbus_d_oe); end
    checks++;
    extbus_rd_n = 1'b0;
    #5;
    if (extbus_d_oe !== 1'b1 || extbus_d_o !== 8'hA1) begin
      failures++; $display("FAIL read_drive got oe=%b d=%h exp oe=1 d=a1", extbus_d_oe, extbus_d_o);
    end
    checks++;
    if (reg_rd_addr !== 5'h04) begin failures++; $display("FAIL read_addr_pass got=%h exp=04", reg_rd_addr); end
    checks++;
    #55 extbus_rd_n = 1'b1;
    #1;
    if (extbus_d_oe !== 1'b0) begin failures++; $display("FAIL read_oe_release got=%b exp=0", extbus_d_oe); end
    checks++;
    #14 extbus_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    if (rd_q.size() != 1) begin failures++; $display("FAIL read_count got=%0d exp=1", rd_q.size()); end
    else if (rd_q[0] !== 5'h04) begin failures++; $display("FAIL read_done_addr got=%h exp=04", rd_q[0]); end
    checks++;
    if (wr_q.size() != 0) begin failures++; $display("FAIL read_no_wr got=%0d exp=0", wr_q.size()); end
    checks++;
    $display("test_read addr=04 data=a1 done_pulses=%0d", rd_q.size());
  endtask

  task automatic test_reset_mid_write();
    wr_q.delete();
    @(posedge clk); #5;
    extbus_a = 5'h07; extbus_d_i = 8'h55;
    #10 extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (reg_wr !== 1'b0 || reg_wr_addr !== 5'd0 || reg_wr_data !== 8'd0) begin
      failures++; $display("FAIL midrst_cleared got=%b %h/%h exp=0 00/00", reg_wr, reg_wr_addr, reg_wr_data);
    end
    checks++;
    #4 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #5 extbus_wr_n = 1'b1; extbus_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    if (wr_q.size() != 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=0", wr_q.size()); end
    checks++;
    bus_write(5'h03, 8'h22);
    repeat (8) @(posedge clk);
    if (wr_q.size() != 1) begin failures++; $display("FAIL midrst_next_count got=%0d exp=1", wr_q.size()); end
    else if (wr_q[0] !== {5'h03, 8'h22}) begin
      failures++; $display("FAIL midrst_next_value got=%h exp=%h", wr_q[0], {5'h03, 8'h22});
    end
    checks++;
    $display("test_reset_mid_write pulses=%0d", wr_q.size());
  endtask

  task automatic test_error();
    bit seen;
    wr_q.delete(); rd_q.delete();
    @(posedge clk); #5;
    extbus_cs_n = 1'b0; extbus_rd_n = 1'b0; extbus_wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus_err); end
    checks++;
    if (extbus_d_oe !== 1'b0) begin failures++; $display("FAIL err_oe got=%b exp=0", extbus_d_oe); end
    checks++;
    #4 extbus_cs_n = 1'b1; extbus_rd_n = 1'b1; extbus_wr_n = 1'b1;
    repeat (8) @(posedge clk);
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      failures++; $display("FAIL err_no_pulse got wr=%0d rd=%0d exp=0/0", wr_q.size(), rd_q.size());
    end
    checks++;
    #1;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus_err); end
    checks++;
    #4 err_clr = 1'b1;
    @(posedge clk); #5 err_clr = 1'b0;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus_err); end
    checks++;
    // Clear held while a new error arrives: set must win for the edge it occurs.
    err_clr = 1'b1; seen = 1'b0;
    extbus_cs_n = 1'b0; extbus_rd_n = 1'b0; extbus_wr_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus_err) seen = 1'b1;
    end
    extbus_cs_n = 1'b1; extbus_rd_n = 1'b1; extbus_wr_n = 1'b1;
    repeat (6) @(posedge clk);
    #5 err_clr = 1'b0;
    if (seen !== 1'b1) begin failures++; $display("FAIL err_set_priority got=%b exp=1", seen); end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL err_clear_after got=%b exp=0", bus_err); end
    checks++;
    // Strobes with chip select high are ignored.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #5 extbus_wr_n = 1'b0; extbus_rd_n = 1'b0;
      #1;
      if (extbus_d_oe !== 1'b0) begin failures++; $display("FAIL nocs_oe%0d got=%b exp=0", i, extbus_d_oe); end
      checks++;
      #60 extbus_rd_n = 1'b1;
      @(posedge clk); #5 extbus_wr_n = 1'b1;
    end
    repeat (8) @(posedge clk);
    if (wr_q.size() != 0 || rd_q.size() != 0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL nocs_ignored got wr=%0d rd=%0d err=%b exp=0/0/0", wr_q.size(), rd_q.size(), bus_err);
    end
    checks++;
    $display("test_error done");
  endtask

  task automatic test_short_strobe();
    wr_q.delete();
    @(posedge clk); #25;
    extbus_a = 5'h06; extbus_d_i = 8'h66;
    extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
    #20 extbus_wr_n = 1'b1; extbus_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    if (wr_q.size() > 1) begin failures++; $display("FAIL short_straddle got=%0d exp<=1", wr_q.size()); end
    checks++;
    wr_q.delete();
    @(posedge clk); #5;
    extbus_cs_n = 1'b0; extbus_wr_n = 1'b0;
    #20 extbus_wr_n = 1'b1; extbus_cs_n = 1'b1;
    repeat (8) @(posedge clk);
    if (wr_q.size() > 1) begin failures++; $display("FAIL short_between got=%0d exp<=1", wr_q.size()); end
    checks++;
    wr_q.delete();
    bus_write(5'h0F, 8'h5A);
    repeat (8) @(posedge clk);
    if (wr_q.size() != 1) begin failures++; $display("FAIL short_recover_count got=%0d exp=1", wr_q.size()); end
    else if (wr_q[0] !== {5'h0F, 8'h5A}) begin
      failures++; $display("FAIL short_recover_value got=%h exp=%h", wr_q[0], {5'h0F, 8'h5A});
    end
    checks++;
    $display("test_short_strobe done");
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0;
    extbus_cs_n = 1'b1; extbus_rd_n = 1'b1; extbus_wr_n = 1'b1;
    extbus_a = 5'd0; extbus_d_i = 8'd0; reg_rd_data = 8'd0;
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_reset_mid_write();
    test_error();
    test_short_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
